// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes, FSM
// encodings and a frame-length helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  // Clocks occupied by one complete frame on the line.
  function automatic int unsigned frame_clks(input int unsigned clks_per_bit,
                                             input int unsigned data_bits,
                                             input int unsigned parity_mode,
                                             input int unsigned stop_bits);
    int unsigned par_bits;
    par_bits = (parity_mode != PARITY_NONE) ? 1 : 0;
    return (1 + data_bits + par_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full flag; pushes while full and pops
// while empty are ignored.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FullCount = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == FullCount);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign full     = full_q;
  assign count    = count_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with input FIFO; frames go out LSB first and
// back-to-back while queued data remains.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic                          i_Tx_Valid,
  input  logic [DATA_BITS-1:0]          i_Tx_Data,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT * 2);
  localparam int unsigned IdxW = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two in 2..64");
  end

  tx_state_e            state_q, state_d;
  logic [CntW-1:0]      clk_cnt_q;
  logic [IdxW-1:0]      bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] data_q, fifo_data;
  logic                 fifo_pop, fifo_empty, fifo_full;
  logic                 bit_end, last_data, last_stop, parity_bit;
  logic                 serial_d, active_d, done_d;
  logic                 serial_q, active_q, done_q;

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_Clock),
    .rst_n    (i_Rst_L),
    .push     (i_Tx_Valid),
    .push_data(i_Tx_Data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (o_Fifo_Count)
  );

  assign bit_end    = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign last_data  = (bit_idx_q == IdxW'(DATA_BITS - 1));
  assign last_stop  = (stop_idx_q == 1'(STOP_BITS - 1));
  assign parity_bit = (PARITY_MODE == PARITY_EVEN) ? ^data_q : ~^data_q;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end && last_data) begin
          state_d = (PARITY_MODE != PARITY_NONE) ? StParity : StStop;
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        // Reload straight into START so consecutive frames share no idle cycle.
        if (bit_end && last_stop) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    serial_d = 1'b1;
    unique case (state_q)
      StIdle:   serial_d = 1'b1;
      StStart:  serial_d = 1'b0;
      StData:   serial_d = data_q[bit_idx_q];
      StParity: serial_d = parity_bit;
      StStop:   serial_d = 1'b1;
      default:  serial_d = 1'b1;
    endcase
    active_d = (state_q != StIdle);
    done_d   = (state_q == StStop) && bit_end && last_stop;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
    end else begin
      if (fifo_pop) data_q <= fifo_data;
      if (state_q == StIdle || bit_end) begin
        clk_cnt_q <= '0;
      end else begin
        clk_cnt_q <= clk_cnt_q + CntW'(1);
      end
      if (state_q == StData && bit_end) begin
        bit_idx_q <= last_data ? '0 : bit_idx_q + IdxW'(1);
      end
      if (state_q == StStop && bit_end) begin
        stop_idx_q <= last_stop ? 1'b0 : 1'b1;
      end
    end
  end

  // Line outputs are registered, so they trail the FSM state by one cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;
  assign o_Tx_Ready  = !fifo_full;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: three instances with different framing,
// a per-cycle line monitor, and scenario tasks run in sequence.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] vld = '0;
  logic [7:0] data_a = '0;
  logic [7:0] data_b = '0;
  logic [6:0] data_c = '0;
  logic [2:0] rdy, ser, act, dn;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  int total = 0;
  int bad = 0;
  int shown = 0;

  logic [8:0] exp_q [3][$];
  logic [8:0] cur [3];
  bit         in_frame [3];
  int         cyc [3];
  int         frames [3];

  always #5 clk = ~clk;

  // A: 8N1, B: 8E1, C: 7O2
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_dut_a (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_Valid(vld[0]), .i_Tx_Data(data_a),
    .o_Tx_Ready(rdy[0]), .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(dn[0]),
    .o_Fifo_Count(cnt_a));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_dut_b (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_Valid(vld[1]), .i_Tx_Data(data_b),
    .o_Tx_Ready(rdy[1]), .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(dn[1]),
    .o_Fifo_Count(cnt_b));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2),
                  .FIFO_DEPTH(4)) u_dut_c (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_Valid(vld[2]), .i_Tx_Data(data_c),
    .o_Tx_Ready(rdy[2]), .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(dn[2]),
    .o_Fifo_Count(cnt_c));

  function automatic int db(input int i);
    return (i == 2) ? 7 : 8;
  endfunction
  function automatic int pm(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction
  function automatic int sb(input int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int flen(input int i);
    return (1 + db(i) + ((pm(i) != 0) ? 1 : 0) + sb(i)) * CPB;
  endfunction

  function automatic logic exp_bit(input logic [8:0] w, input int i, input int c);
    int   b;
    logic par;
    b   = c / CPB;
    par = ^w;
    if (b == 0) return 1'b0;
    if (b <= db(i)) return w[b-1];
    if (pm(i) != 0 && b == db(i) + 1) return (pm(i) == 2) ? par : ~par;
    return 1'b1;
  endfunction

  // Line monitor: pops the expected word at each start bit and checks every cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        in_frame[i] = 1'b0;
        exp_q[i].delete();
      end else begin
        if (!in_frame[i] && ser[i] === 1'b0) begin
          total++;
          if (exp_q[i].size() == 0) begin
            bad++;
            if (shown++ < 40) $display("FAIL unexpected_frame dut=%0d t=%0t", i, $time);
          end else begin
            cur[i]      = exp_q[i].pop_front();
            in_frame[i] = 1'b1;
            cyc[i]      = 0;
          end
        end
        if (in_frame[i]) begin
          total++;
          if (ser[i] !== exp_bit(cur[i], i, cyc[i])) begin
            bad++;
            if (shown++ < 40)
              $display("FAIL serial_bit dut=%0d word=%h cyc=%0d got=%b want=%b", i, cur[i],
                       cyc[i], ser[i], exp_bit(cur[i], i, cyc[i]));
          end
          total++;
          if (act[i] !== 1'b1) begin
            bad++;
            if (shown++ < 40) $display("FAIL active_in_frame dut=%0d cyc=%0d got=%b want=1",
                                       i, cyc[i], act[i]);
          end
          total++;
          if (dn[i] !== (cyc[i] == flen(i) - 1)) begin
            bad++;
            if (shown++ < 40) $display("FAIL done_timing dut=%0d cyc=%0d got=%b want=%b", i,
                                       cyc[i], dn[i], (cyc[i] == flen(i) - 1));
          end
          cyc[i]++;
          if (cyc[i] == flen(i)) begin
            in_frame[i] = 1'b0;
            frames[i]++;
          end
        end else begin
          total++;
          if (ser[i] !== 1'b1 || act[i] !== 1'b0 || dn[i] !== 1'b0) begin
            bad++;
            if (shown++ < 40) $display("FAIL idle_line dut=%0d got ser=%b act=%b done=%b want 1/0/0",
                                       i, ser[i], act[i], dn[i]);
          end
        end
      end
    end
  end

  task automatic push(input int i, input logic [8:0] d, output bit acc);
    logic [8:0] m;
    m = (i == 2) ? (d & 9'h07F) : (d & 9'h0FF);
    vld[i] = 1'b1;
    case (i)
      0:       data_a = m[7:0];
      1:       data_b = m[7:0];
      default: data_c = m[6:0];
    endcase
    acc = rdy[i];
    if (acc) exp_q[i].push_back(m);
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (frames[i] >= target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #23;
    total++;
    if (ser !== 3'b111 || act !== 3'b000 || dn !== 3'b000) begin
      bad++;
      $display("FAIL reset_line got ser=%b act=%b done=%b want 111/000/000", ser, act, dn);
    end
    total++;
    if (rdy !== 3'b111 || cnt_a !== 3'd0 || cnt_b !== 3'd0 || cnt_c !== 3'd0) begin
      bad++;
      $display("FAIL reset_fifo got rdy=%b cnt=%0d/%0d/%0d want 111 0/0/0", rdy, cnt_a,
               cnt_b, cnt_c);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_basic_latency();
    bit acc, ok;
    int f0;
    f0 = frames[0];
    push(0, 9'h0A5, acc);
    total++;
    if (!acc || cnt_a !== 3'd1 || ser[0] !== 1'b1) begin
      bad++;
      $display("FAIL push_edge got acc=%b cnt=%0d ser=%b want 1 1 1", acc, cnt_a, ser[0]);
    end
    @(posedge clk);
    #1;
    total++;
    if (ser[0] !== 1'b1 || cnt_a !== 3'd0) begin
      bad++;
      $display("FAIL latency_n1 got ser=%b cnt=%0d want 1 0", ser[0], cnt_a);
    end
    @(posedge clk);
    #1;
    total++;
    if (ser[0] !== 1'b0) begin
      bad++;
      $display("FAIL latency_n2 got ser=%b want 0", ser[0]);
    end
    wait_frames(0, f0 + 1, 100, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_frame got frames=%0d want %0d", frames[0], f0 + 1);
    end
  endtask

  task automatic test_parity();
    bit acc, ok, seen;
    int n, fb, fc;
    fb = frames[1];
    fc = frames[2];
    push(1, 9'h0A5, acc);
    push(2, 9'h0A5, acc);
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (act[1]) begin
        seen = 1'b1;
        n++;
      end else if (seen) begin
        break;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (n != 44) begin
      bad++;
      $display("FAIL parity_frame_len got %0d want 44", n);
    end
    wait_frames(2, fc + 1, 100, ok);
    total++;
    if (frames[1] != fb + 1 || !ok) begin
      bad++;
      $display("FAIL parity_frames got %0d/%0d want %0d/%0d", frames[1], frames[2], fb + 1,
               fc + 1);
    end
  endtask

  task automatic test_back_to_back();
    bit a1, a2, seen;
    int n, f0;
    f0 = frames[2];
    push(2, 9'h07F, a1);
    push(2, 9'h000, a2);
    total++;
    if (!a1 || !a2) begin
      bad++;
      $display("FAIL b2b_accept got %b%b want 11", a1, a2);
    end
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (act[2]) begin
        seen = 1'b1;
        n++;
      end else if (seen) begin
        break;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (n != 88) begin
      bad++;
      $display("FAIL b2b_active_len got %0d want 88", n);
    end
    total++;
    if (frames[2] != f0 + 2) begin
      bad++;
      $display("FAIL b2b_done_count got %0d want %0d", frames[2] - f0, 2);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_fill();
    bit acc, ok, checked4;
    int nacc, f0;
    logic [7:0] nxt;
    f0 = frames[0];
    push(0, 9'h010, acc);
    repeat (3) begin @(posedge clk); #1; end
    nacc = 0;
    nxt = 8'h20;
    checked4 = 1'b0;
    for (int k = 0; k < 400 && nacc < 10; k++) begin
      vld[0] = 1'b1;
      data_a = nxt;
      total++;
      if (cnt_a > 3'd4) begin
        bad++;
        $display("FAIL fill_count_max got %0d want <=4", cnt_a);
      end
      total++;
      if (rdy[0] !== (cnt_a != 3'd4)) begin
        bad++;
        $display("FAIL fill_ready got %b want %b (cnt=%0d)", rdy[0], (cnt_a != 3'd4), cnt_a);
      end
      if (nacc == 4 && !checked4) begin
        checked4 = 1'b1;
        total++;
        if (rdy[0] !== 1'b0 || cnt_a !== 3'd4) begin
          bad++;
          $display("FAIL ready_after_4 got rdy=%b cnt=%0d want 0 4", rdy[0], cnt_a);
        end
      end
      if (rdy[0]) begin
        exp_q[0].push_back({1'b0, nxt});
        nxt = nxt + 8'd1;
        nacc++;
      end
      @(posedge clk);
      #1;
    end
    vld[0] = 1'b0;
    total++;
    if (nacc != 10) begin
      bad++;
      $display("FAIL fill_accepts got %0d want 10", nacc);
    end
    wait_frames(0, f0 + 11, 700, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL fill_drain got frames=%0d want %0d", frames[0] - f0, 11);
    end
  endtask

  task automatic test_push_on_pop();
    bit acc, ok;
    int f0;
    f0 = frames[0];
    push(0, 9'h03C, acc);
    repeat (4) begin @(posedge clk); #1; end
    push(0, 9'h0C3, acc);
    repeat (35) begin @(posedge clk); #1; end
    push(0, 9'h05A, acc);
    total++;
    if (!acc || cnt_a !== 3'd1) begin
      bad++;
      $display("FAIL push_on_pop_count got acc=%b cnt=%0d want 1 1", acc, cnt_a);
    end
    @(posedge clk);
    #1;
    total++;
    if (ser[0] !== 1'b0 || act[0] !== 1'b1) begin
      bad++;
      $display("FAIL no_gap got ser=%b act=%b want 0 1", ser[0], act[0]);
    end
    wait_frames(0, f0 + 3, 200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL push_on_pop_frames got %0d want %0d", frames[0] - f0, 3);
    end
  endtask

  task automatic test_reset_mid();
    bit acc, ok, went_low;
    int f0;
    f0 = frames[0];
    push(0, 9'h0F0, acc);
    push(0, 9'h00F, acc);
    push(0, 9'h066, acc);
    repeat (10) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (ser[0] !== 1'b1 || cnt_a !== 3'd0 || act[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid got ser=%b cnt=%0d act=%b rdy=%b want 1 0 0 1", ser[0], cnt_a,
               act[0], rdy[0]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    went_low = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (ser[0] !== 1'b1 || cnt_a !== 3'd0) went_low = 1'b1;
      @(posedge clk);
      #1;
    end
    total++;
    if (went_low || frames[0] != f0) begin
      bad++;
      $display("FAIL reset_quiet got activity=%b frames=%0d want 0 %0d", went_low, frames[0],
               f0);
    end
    push(0, 9'h099, acc);
    wait_frames(0, f0 + 1, 100, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL after_reset_frame got %0d want %0d", frames[0] - f0, 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_parity();
    test_back_to_back();
    test_fill();
    test_push_on_pop();
    test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (exp_q[i].size() != 0 || in_frame[i]) begin
        bad++;
        $display("FAIL leftover dut=%0d got queued=%0d want 0", i, exp_q[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised next-generation UART transmitter for the AES serial link.
- Data width, parity, stop-bit count and baud divisor are set by parameter.
- A small input FIFO with valid/ready handshake lets the AES result streamer queue ciphertext bytes without waiting on each frame.
- Frames are sent LSB first, back-to-back, with no idle gap while the FIFO holds data.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even; 3 is illegal.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- FIFO_DEPTH, 4, input FIFO entries; power of two, 2..64.

Ports:
- i_Clock  input  1  system clock.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_Tx_Valid  input  1  write request.
- i_Tx_Data  input  DATA_BITS  payload, accepted when i_Tx_Valid & o_Tx_Ready.
- o_Tx_Ready  output  1  FIFO not full.
- o_Tx_Serial  output  1  serial line; idle high; registered.
- o_Tx_Active  output  1  high from the first start-bit cycle to the last stop-bit cycle of a frame.
- o_Tx_Done  output  1  one-cycle pulse per completed frame.
- o_Fifo_Count  output  $clog2(FIFO_DEPTH)+1  entries currently queued.

Behaviour:
- Reset (async assert, sync deassert internally by flops):
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, o_Fifo_Count=0.
  - FIFO emptied, FSM to IDLE.
  - Reset mid-frame aborts the frame; the line returns high immediately.
- FIFO:
  - Push on i_Tx_Valid & o_Tx_Ready; o_Tx_Ready = !full, registered.
  - Pop when the FSM loads a word.
  - Simultaneous push and pop: count unchanged, both take effect.
  - A push while full is ignored; ready is low, so no data is corrupted.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line high. If the FIFO is non-empty, pop into the shift register, set active, go to START.
  - START: line 0 for exactly CLKS_PER_BIT cycles.
  - DATA: bit index 0..DATA_BITS-1, each held CLKS_PER_BIT cycles. Index wraps to 0 after the last bit.
  - PARITY: entered only if PARITY_MODE != 0, otherwise skipped. One bit:
    - even mode: XOR of the payload;
    - odd mode: inverted XOR of the payload;
    - parity is computed from the latched word, not from live input.
  - STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle:
    - o_Tx_Done=1 for that single cycle;
    - if the FIFO is non-empty, pop and go directly to START, so the next start bit follows with no idle cycle and o_Tx_Active stays high;
    - otherwise go to IDLE and clear o_Tx_Active.
- Frame length: (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT cycles exactly. No extra cycle per bit; no cleanup state.
- Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE gives o_Tx_Serial=0 after edge N+2.
- Bit counter width: $clog2(CLKS_PER_BIT*2). It is reset to 0 at each bit boundary and never wraps mid-bit.
- Illegal parameters are caught by elaboration-time checks that stop simulation.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PARITY_NONE/ODD/EVEN;
  - FSM state enum encodings;
  - a function computing frame length in clocks.
- One sub-module: uart_sync_fifo, parametrised by WIDTH and DEPTH, with push/pop/full/empty/count.
- The FSM, baud counter and parity logic stay in uart_tx_param.

Test Plan:
- Settings CLKS_PER_BIT=4, DATA_BITS=8, no parity, 1 stop; push 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. Frame is 40 cycles. o_Tx_Done pulses once on cycle 40.
- PARITY_MODE=2, push 0xA5 (four ones) -> parity bit 0. PARITY_MODE=1 -> parity bit 1. Frame is 44 cycles.
- Settings DATA_BITS=7, STOP_BITS=2; push 0x7F and 0x00 on consecutive cycles -> second start bit immediately follows 8 stop cycles. o_Tx_Active stays high for 88 cycles; o_Tx_Done pulses twice.
- Hold i_Tx_Valid high with FIFO_DEPTH=4 while the FSM is busy -> o_Tx_Ready drops after 4 accepts, then re-asserts one cycle after the next pop. All accepted bytes are transmitted in order; count never exceeds 4.
- Assert i_Rst_L low mid-DATA with 2 words queued -> o_Tx_Serial=1 and o_Fifo_Count=0 immediately. After release, no frame is sent until a new push.
- Push on the exact cycle the FSM pops the last entry -> count stays 1 and the word is transmitted next with no gap.
